// File: rtl/adder_chain_ctrl.sv
// rtl/adder_chain_ctrl.sv - byte-serial wide adder sequencer driving an external registered 8-bit adder
//
// Purpose:
//   Adds two W-bit operands (W = 8*NBYTES) plus a carry-in by streaming one
//   byte pair at a time, least-significant byte first, through an external
//   8-bit adder whose sum and carry come back one clock after the operands.
//   Each byte takes two cycles (ISSUE then WAIT), so start sampled in cycle 0
//   yields the done pulse in cycle 2*NBYTES+1.
//
// Ports:
//   clock      in   rising-edge clock, shared with the adder stage
//   reset_n    in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE or DONE
//   op_a       in   W   first operand, latched on accepted start
//   op_b       in   W   second operand, latched on accepted start
//   cin        in   carry-in, latched on accepted start
//   busy       out  high in ISSUE and WAIT
//   done       out  one-cycle pulse when result/cout are valid
//   result     out  W   assembled sum, bytes update as each WAIT closes
//   cout       out  final carry-out, updated on DONE entry
//   add_a      out  8   byte operand A to the adder stage (0 outside ISSUE)
//   add_b      out  8   byte operand B to the adder stage (0 outside ISSUE)
//   add_cin    out  carry-in to the adder stage (0 outside ISSUE)
//   add_sum    in   8   registered sum from the adder stage
//   add_carry  in   registered carry from the adder stage

module adder_chain_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_carry
);

  localparam int W    = 8 * NBYTES;
  // Keep the index at least one bit wide so NBYTES=1 still elaborates.
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic            creg;
  logic [IDXW-1:0] idx;
  logic            accept;
  logic            last_byte;

  // A start is honoured only when no chain is in flight, which is also what
  // keeps the latched operands stable mid-chain.
  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_byte = (idx == LAST_IDX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    add_a      = 8'h00;
    add_b      = 8'h00;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        busy       = 1'b1;
        add_a      = a_reg[{idx, 3'b000} +: 8];
        add_b      = b_reg[{idx, 3'b000} +: 8];
        add_cin    = creg;
        state_next = WAIT;
      end
      WAIT: begin
        busy       = 1'b1;
        state_next = last_byte ? DONE : ISSUE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = accept ? ISSUE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers. result and cout are deliberately not cleared on a new
  // start: they hold the previous answer until this chain overwrites them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      creg   <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_reg <= op_a;
      b_reg <= op_b;
      creg  <= cin;
      idx   <= '0;
    end else if (state == WAIT) begin
      // The adder's registered outputs are valid during WAIT; the carry of
      // this byte becomes the carry-in of the next.
      result[{idx, 3'b000} +: 8] <= add_sum;
      creg                       <= add_carry;
      if (last_byte) begin
        cout <= add_carry;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adder_chain_ctrl.sv
// tb/tb_adder_chain_ctrl.sv - directed self-checking bench for adder_chain_ctrl

module tb_adder_chain_ctrl;

  localparam int NBYTES = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_sum = '0;
  logic        add_carry = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Registered 8-bit adder stage: result appears one clock after operands.
  always_ff @(posedge clock) begin
    {add_carry, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
  end

  adder_chain_ctrl #(.NBYTES(NBYTES)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_carry (add_carry)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_at(input logic [31:0] a, input logic [31:0] b, input logic ci);
    @(posedge clock);
    #1;
    op_a  = a;
    op_b  = b;
    cin   = ci;
    start = 1'b1;
  endtask

  // Walks cycles 0..9 of one chain. cin_seq bit i is the hand-computed carry
  // into byte i. cont=1 means the caller is already at the cycle-0 sample point.
  task automatic run_chain(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] cin_seq,
                           input logic [31:0] exp_r, input logic exp_c,
                           input logic [31:0] prev_r, input logic prev_c,
                           input bit mid_start, input bit cont);
    for (int c = 0; c <= 9; c++) begin
      if (!(c == 0 && cont)) @(negedge clock);
      check($sformatf("busy_c%0d", c), busy, (c >= 1 && c <= 8));
      if (c != 0) check($sformatf("done_c%0d", c), done, (c == 9));
      if ((c % 2 == 1) && (c <= 7)) begin
        check($sformatf("add_a_c%0d", c), add_a, a[(c/2)*8 +: 8]);
        check($sformatf("add_b_c%0d", c), add_b, b[(c/2)*8 +: 8]);
        check($sformatf("add_cin_c%0d", c), add_cin, cin_seq[c/2]);
      end else begin
        check($sformatf("add_a_zero_c%0d", c), add_a, 8'h00);
        check($sformatf("add_b_zero_c%0d", c), add_b, 8'h00);
        check($sformatf("add_cin_zero_c%0d", c), add_cin, 1'b0);
      end
      if (c == 2) check("result_held", result, prev_r);
      if (c == 8) check("cout_held", cout, prev_c);
      if (c == 9) begin
        check("result", result, exp_r);
        check("cout", cout, exp_c);
      end
      if (c < 9) begin
        @(posedge clock);
        #1;
        if (c == 0) start = 1'b0;
        if (mid_start && c == 3) begin
          start = 1'b1;
          op_a  = 32'h11111111;
          op_b  = 32'h22222222;
          cin   = 1'b1;
        end
        if (mid_start && c == 4) start = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_add_a", add_a, 8'h00);
    check("rst_add_b", add_b, 8'h00);
    check("rst_add_cin", add_cin, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 0xFF + 0x01: carry out of byte 0 only
    start_at(32'h000000FF, 32'h00000001, 1'b0);
    run_chain(32'h000000FF, 32'h00000001, 4'b0010, 32'h00000100, 1'b0,
              32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("done_pulse_end", done, 1'b0);
    check("result_idle_hold", result, 32'h00000100);

    // Full ripple
    start_at(32'hFFFFFFFF, 32'h00000000, 1'b1);
    run_chain(32'hFFFFFFFF, 32'h00000000, 4'b1111, 32'h00000000, 1'b1,
              32'h00000100, 1'b0, 1'b0, 1'b0);

    // Mixed bytes, with an ignored start during WAIT (cycle 4)
    start_at(32'h12345678, 32'h9ABCDEF0, 1'b0);
    run_chain(32'h12345678, 32'h9ABCDEF0, 4'b0110, 32'hACF13568, 1'b0,
              32'h00000000, 1'b1, 1'b1, 1'b0);

    // Back-to-back: start held high in the DONE cycle just checked
    op_a  = 32'h000000FF;
    op_b  = 32'h00000001;
    cin   = 1'b0;
    start = 1'b1;
    run_chain(32'h000000FF, 32'h00000001, 4'b0010, 32'h00000100, 1'b0,
              32'hACF13568, 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    check("b2b_done_end", done, 1'b0);

    // Reset in cycle 4 aborts the chain
    start_at(32'h000000FF, 32'h00000001, 1'b0);
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_result", result, 32'h0);
    check("arst_cout", cout, 1'b0);
    check("arst_add_a", add_a, 8'h00);
    check("arst_add_cin", add_cin, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("arst_no_done_%0d", i), done, 1'b0);
      check($sformatf("arst_no_busy_%0d", i), busy, 1'b0);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Same stimulus as the first chain after reset
    start_at(32'h000000FF, 32'h00000001, 1'b0);
    run_chain(32'h000000FF, 32'h00000001, 4'b0010, 32'h00000100, 1'b0,
              32'h0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
